// File: rtl/game_pkg.sv
// Shared game constants, player state encoding and small helpers used by
// the motion and render blocks.
package game_pkg;

  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int PLAYER_W   = 20;
  localparam int PLAYER_H   = 20;
  localparam int FLOOR_Y    = 440;
  localparam int SPAWN_X    = 40;
  localparam int SPAWN_Y    = 300;
  localparam int WALK_SPEED = 3;
  localparam int JUMP1_V    = 8;
  localparam int JUMP2_V    = 7;
  localparam int GRAVITY    = 1;
  localparam int VMAX       = 9;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    AIR1   = 2'd1,
    AIR2   = 2'd2,
    DEAD   = 2'd3
  } motion_state_t;

  // Accelerate downward by one gravity step, capped at terminal speed.
  function automatic logic signed [5:0] fall_speed(input logic signed [5:0] vy);
    logic signed [5:0] v;
    v = vy + $signed(6'(GRAVITY));
    return (v > $signed(6'(VMAX))) ? $signed(6'(VMAX)) : v;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector; emits a single
// clk-wide pulse for each rise of an asynchronous input.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic sync_prev;

  // NOTE: non-blocking assignments make these three flops a real shift chain;
  // blocking ones would collapse them into a single stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= din;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign rise = sync2 & ~sync_prev;

endmodule

// File: rtl/player_motion.sv
// Per-step player physics: walking, gravity, single/double jump, floor,
// ceiling and wall clamping, death and respawn.
module player_motion
  import game_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          update_clk,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          btn_jump,
  input  logic          hazard,
  output logic [9:0]    pos_x,
  output logic [9:0]    pos_y,
  output logic          facing,
  output motion_state_t state,
  output logic [7:0]    deaths
);

  localparam logic signed [11:0] X_MAX    = 12'(SCREEN_W - PLAYER_W);
  localparam logic signed [11:0] Y_LAND   = 12'(FLOOR_Y - PLAYER_H);
  localparam logic signed [11:0] WALK     = 12'(WALK_SPEED);
  localparam logic signed [5:0]  VY_JUMP1 = 6'(-JUMP1_V);
  localparam logic signed [5:0]  VY_JUMP2 = 6'(-JUMP2_V);
  localparam logic [9:0]         X_SPAWN  = 10'(SPAWN_X);
  localparam logic [9:0]         Y_SPAWN  = 10'(SPAWN_Y);

  logic                step;
  logic                jump_prev;
  logic                jump_edge;
  logic signed [5:0]   vy;
  logic signed [5:0]   vy_new;
  logic signed [5:0]   vy_nx;
  logic [9:0]          x_nx;
  logic [9:0]          y_nx;
  logic                facing_nx;
  logic [7:0]          deaths_nx;
  motion_state_t       state_nx;
  motion_state_t       air_state;
  logic signed [11:0]  y_sum;
  logic signed [11:0]  x_sum;

  edge_sync u_step_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (update_clk),
    .rise (step)
  );

  assign jump_edge = btn_jump & ~jump_prev;

  // NOTE: every variable gets a default before any branch, so no latch is
  // inferred on paths that leave it untouched.
  always_comb begin
    x_nx      = pos_x;
    y_nx      = pos_y;
    vy_nx     = vy;
    facing_nx = facing;
    deaths_nx = deaths;
    state_nx  = state;
    vy_new    = vy;
    air_state = state;
    y_sum     = '0;
    x_sum     = '0;

    if (state != DEAD && hazard) begin
      state_nx = DEAD;
      if (deaths != 8'hFF) deaths_nx = deaths + 8'd1;
    end else if (state == DEAD) begin
      if (jump_edge) begin
        x_nx     = X_SPAWN;
        y_nx     = Y_SPAWN;
        vy_nx    = '0;
        state_nx = AIR1;
      end
    end else begin
      unique case (state)
        GROUND: begin
          if (jump_edge) begin
            vy_new    = VY_JUMP1;
            air_state = AIR1;
          end else begin
            vy_new = '0;
          end
        end
        AIR1: begin
          if (jump_edge) begin
            vy_new    = VY_JUMP2;
            air_state = AIR2;
          end else begin
            vy_new = fall_speed(vy);
          end
        end
        default: vy_new = fall_speed(vy);
      endcase

      // Landing takes precedence: it also returns airborne states to GROUND.
      y_sum = $signed({2'b00, pos_y}) + $signed({{6{vy_new[5]}}, vy_new});
      if (y_sum >= Y_LAND) begin
        y_nx     = Y_LAND[9:0];
        vy_nx    = '0;
        state_nx = GROUND;
      end else if (y_sum < 12'sd0) begin
        y_nx     = '0;
        vy_nx    = '0;
        state_nx = air_state;
      end else begin
        y_nx     = y_sum[9:0];
        vy_nx    = vy_new;
        state_nx = air_state;
      end

      if (btn_left ^ btn_right) begin
        facing_nx = btn_right;
        x_sum     = btn_right ? $signed({2'b00, pos_x}) + WALK
                              : $signed({2'b00, pos_x}) - WALK;
        if (x_sum < 12'sd0)     x_nx = '0;
        else if (x_sum > X_MAX) x_nx = X_MAX[9:0];
        else                    x_nx = x_sum[9:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_x     <= X_SPAWN;
      pos_y     <= Y_SPAWN;
      vy        <= '0;
      state     <= AIR1;
      facing    <= 1'b1;
      deaths    <= '0;
      jump_prev <= 1'b0;
    end else if (step) begin
      pos_x     <= x_nx;
      pos_y     <= y_nx;
      vy        <= vy_nx;
      state     <= state_nx;
      facing    <= facing_nx;
      deaths    <= deaths_nx;
      jump_prev <= btn_jump;
    end
  end

endmodule

// File: tb/tb_player_motion.sv
// Self-checking bench for player_motion: constant vector table, hand-written
// corner sequences and randomized steps against a behavioural model.
module tb_player_motion;
  import game_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          update_clk = 1'b0;
  logic          btn_left = 1'b0;
  logic          btn_right = 1'b0;
  logic          btn_jump = 1'b0;
  logic          hazard = 1'b0;
  logic [9:0]    pos_x;
  logic [9:0]    pos_y;
  logic          facing;
  motion_state_t state;
  logic [7:0]    deaths;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int m_x, m_y, m_vy, m_st, m_face, m_deaths;
  bit m_jprev;

  typedef struct {
    int n;
    bit l, r, j, h;
    int x, y, st, face, dth;
  } vec_t;

  vec_t tbl[18];

  player_motion dut (
    .clk        (clk),
    .rst        (rst),
    .update_clk (update_clk),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_jump   (btn_jump),
    .hazard     (hazard),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .facing     (facing),
    .state      (state),
    .deaths     (deaths)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int x, input int y,
                               input int st, input int face, input int dth);
    check({tag, ".pos_x"},  int'(pos_x),  x);
    check({tag, ".pos_y"},  int'(pos_y),  y);
    check({tag, ".state"},  int'(state),  st);
    check({tag, ".facing"}, int'(facing), face);
    check({tag, ".deaths"}, int'(deaths), dth);
  endtask

  task automatic check_model(input string tag);
    check_outputs(tag, m_x, m_y, m_st, m_face, m_deaths);
  endtask

  task automatic model_reset();
    m_x = SPAWN_X; m_y = SPAWN_Y; m_vy = 0; m_st = int'(AIR1);
    m_face = 1; m_deaths = 0; m_jprev = 0;
  endtask

  // One physics step written directly from the game rules.
  task automatic model_step(input bit l, input bit r, input bit j, input bit h);
    bit je;
    int vn, ns, yn;
    je = j && !m_jprev;
    m_jprev = j;
    if (m_st != int'(DEAD) && h) begin
      m_st = int'(DEAD);
      if (m_deaths < 255) m_deaths++;
    end else if (m_st == int'(DEAD)) begin
      if (je) begin
        m_x = SPAWN_X; m_y = SPAWN_Y; m_vy = 0; m_st = int'(AIR1);
      end
    end else begin
      ns = m_st;
      if (m_st == int'(GROUND)) begin
        if (je) begin vn = -JUMP1_V; ns = int'(AIR1); end
        else vn = 0;
      end else if (m_st == int'(AIR1) && je) begin
        vn = -JUMP2_V; ns = int'(AIR2);
      end else begin
        vn = (m_vy + GRAVITY > VMAX) ? VMAX : m_vy + GRAVITY;
      end
      yn = m_y + vn;
      if (yn + PLAYER_H >= FLOOR_Y) begin
        m_y = FLOOR_Y - PLAYER_H; m_vy = 0; m_st = int'(GROUND);
      end else if (yn < 0) begin
        m_y = 0; m_vy = 0; m_st = ns;
      end else begin
        m_y = yn; m_vy = vn; m_st = ns;
      end
      if (l != r) begin
        m_face = r ? 1 : 0;
        if (l) m_x = (m_x - WALK_SPEED < 0) ? 0 : m_x - WALK_SPEED;
        else   m_x = (m_x + WALK_SPEED > SCREEN_W - PLAYER_W) ? SCREEN_W - PLAYER_W
                                                             : m_x + WALK_SPEED;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; update_clk = 1'b0;
    btn_left = 0; btn_right = 0; btn_jump = 0; hazard = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Raise update_clk with inputs held; the step lands on the third clk edge.
  task automatic do_step(input bit l, input bit r, input bit j, input bit h);
    @(negedge clk);
    btn_left = l; btn_right = r; btn_jump = j; hazard = h;
    update_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_step(l, r, j, h);
    @(negedge clk);
    update_clk = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int jumps;
    int prev_st;
    bit go_right;

    tbl[0]  = '{1,  0,0,0,0,  40, 301, int'(AIR1),   1, 0};
    tbl[1]  = '{8,  0,0,0,0,  40, 345, int'(AIR1),   1, 0};
    tbl[2]  = '{8,  0,0,0,0,  40, 417, int'(AIR1),   1, 0};
    tbl[3]  = '{1,  0,0,0,0,  40, 420, int'(GROUND), 1, 0};
    tbl[4]  = '{2,  0,0,0,0,  40, 420, int'(GROUND), 1, 0};
    tbl[5]  = '{1,  0,0,1,0,  40, 412, int'(AIR1),   1, 0};
    tbl[6]  = '{1,  0,0,0,0,  40, 405, int'(AIR1),   1, 0};
    tbl[7]  = '{1,  0,0,1,0,  40, 398, int'(AIR2),   1, 0};
    tbl[8]  = '{1,  0,0,0,0,  40, 392, int'(AIR2),   1, 0};
    tbl[9]  = '{1,  0,0,1,0,  40, 387, int'(AIR2),   1, 0};
    tbl[10] = '{13, 1,0,0,0,   1, 413, int'(AIR2),   0, 0};
    tbl[11] = '{1,  1,0,0,0,   0, 420, int'(GROUND), 0, 0};
    tbl[12] = '{1,  1,1,0,0,   0, 420, int'(GROUND), 0, 0};
    tbl[13] = '{1,  0,1,0,0,   3, 420, int'(GROUND), 1, 0};
    tbl[14] = '{1,  0,0,0,1,   3, 420, int'(DEAD),   1, 1};
    tbl[15] = '{5,  1,0,0,0,   3, 420, int'(DEAD),   1, 1};
    tbl[16] = '{5,  1,0,0,1,   3, 420, int'(DEAD),   1, 1};
    tbl[17] = '{1,  0,0,1,0,  40, 300, int'(AIR1),   1, 1};

    do_reset();
    #1;
    check_outputs("reset", SPAWN_X, SPAWN_Y, int'(AIR1), 1, 0);

    // Table: fall, land, jumps, walls, death and respawn
    for (int i = 0; i < 18; i++) begin
      for (int k = 0; k < tbl[i].n; k++) do_step(tbl[i].l, tbl[i].r, tbl[i].j, tbl[i].h);
      check_outputs($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].st, tbl[i].face, tbl[i].dth);
    end

    // Held jump: land first, then hold jump for 40 steps -> exactly one jump
    for (int k = 0; k < 20; k++) do_step(0, 0, 0, 0);
    check_outputs("land2", SPAWN_X, FLOOR_Y - PLAYER_H, int'(GROUND), 1, 1);
    jumps = 0;
    for (int k = 0; k < 40; k++) begin
      prev_st = int'(state);
      do_step(0, 0, 1, 0);
      if (prev_st == int'(GROUND) && state == AIR1) jumps++;
      if (state == AIR2) check($sformatf("held_no_air2_%0d", k), int'(state), int'(AIR1));
    end
    check("held_jump_count", jumps, 1);
    check_outputs("held_end", SPAWN_X, FLOOR_Y - PLAYER_H, int'(GROUND), 1, 1);
    check_model("held_model");

    // Death counter saturation
    for (int k = 0; k < 256; k++) begin
      do_step(0, 0, 0, 1);
      do_step(0, 0, 1, 0);
    end
    check_outputs("saturate", SPAWN_X, SPAWN_Y, int'(AIR1), 1, 255);
    do_step(0, 0, 0, 1);
    check("saturate_dead.deaths", int'(deaths), 255);

    // Randomized steps against the model
    do_reset();
    #1;
    check_outputs("reset2", SPAWN_X, SPAWN_Y, int'(AIR1), 1, 0);
    for (int k = 0; k < 300; k++) begin
      do_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
      check_model($sformatf("rand%0d", k));
    end

    // Ensure a live state, then hold update_clk high for 1000 clk: one step only
    do_step(0, 0, 1, 0);
    go_right = (m_x < 300);
    @(negedge clk);
    btn_left = !go_right; btn_right = go_right; btn_jump = 0; hazard = 0;
    update_clk = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("latency_pre.pos_x", int'(pos_x), m_x);
    @(posedge clk);
    #1;
    model_step(!go_right, go_right, 0, 0);
    check("latency_post.pos_x", int'(pos_x), m_x);
    repeat (1000) @(posedge clk);
    #1;
    check_model("hold_high");
    @(negedge clk);
    update_clk = 1'b0;
    repeat (3) @(posedge clk);

    // Reset coincident with a step strobe: reset wins
    @(negedge clk);
    btn_left = 1; btn_right = 0; btn_jump = 1; hazard = 0;
    update_clk = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    update_clk = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("rst_strobe", SPAWN_X, SPAWN_Y, int'(AIR1), 1, 0);
    @(negedge clk);
    rst = 1'b0;
    btn_left = 0; btn_jump = 0;
    model_reset();
    repeat (6) @(posedge clk);
    #1;
    check_outputs("rst_after", SPAWN_X, SPAWN_Y, int'(AIR1), 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/player_motion.md
Name: player_motion

Overview:
Per-frame player physics for the kid: walking, gravity, single/double jump, floor/ceiling/wall clamping, death and respawn. Sits directly upstream of render. It consumes the 50 Hz update clock as a sampled strobe and produces the registered player position and state that render draws each VGA frame. Runs entirely on the 100 MHz system clock.

Parameters:
SCREEN_W, 640, playfield width in pixels
SCREEN_H, 480, playfield height in pixels
PLAYER_W, 20, sprite width
PLAYER_H, 20, sprite height
FLOOR_Y, 440, y of the ground's top edge
SPAWN_X, 40, respawn / reset x
SPAWN_Y, 300, respawn / reset y
WALK_SPEED, 3, pixels per step horizontally
JUMP1_V, 8, first-jump upward speed
JUMP2_V, 7, double-jump upward speed
GRAVITY, 1, vy increment per step
VMAX, 9, terminal downward speed

Ports:
clk  in  1  system clock
rst  in  1  reset
update_clk  in  1  50 Hz update clock, sampled as data
btn_left  in  1  debounced level, move left
btn_right  in  1  debounced level, move right
btn_jump  in  1  debounced level, jump
hazard  in  1  player overlaps a spike; valid level
pos_x  out  10  sprite left edge
pos_y  out  10  sprite top edge
facing  out  1  1 = right, 0 = left
state  out  2  GROUND / AIR1 / AIR2 / DEAD
deaths  out  8  death counter, saturating

Behaviour:
- Clocking/reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: pos_x=SPAWN_X, pos_y=SPAWN_Y, vy=0, state=AIR1, facing=1, deaths=0, sync flops=0, jump_prev=0. Reset wins over a coincident step.
- Step strobe: update_clk passes through a 2-FF synchroniser plus a rising-edge detect, giving exactly one step per update_clk rise. A constant-high input produces no further steps. Outputs update on the clk edge after the step strobe, 3 clk after update_clk rises.
- jump_edge = btn_jump & ~jump_prev. jump_prev is updated on every step, including steps in DEAD.
- Step priority:
  1. hazard
  2. state-specific jump
  3. vertical motion
  4. horizontal motion
- Hazard: in any non-DEAD state, go to DEAD and increment deaths, saturating at 255. Position, facing and vy are frozen.
- DEAD: hazard is ignored. A jump_edge respawns: pos=(SPAWN_X, SPAWN_Y), vy=0, state AIR1. No motion on that step.
- GROUND:
  - jump_edge: vy_new=-JUMP1_V, go to AIR1.
  - otherwise: vy_new=0.
- AIR1:
  - jump_edge: vy_new=-JUMP2_V, go to AIR2.
  - otherwise: vy_new=min(vy+GRAVITY, VMAX).
- AIR2: vy_new=min(vy+GRAVITY, VMAX). Jump is ignored.
- Vertical motion:
  - y_next = pos_y + vy_new, computed signed 12-bit. vy is signed 6-bit.
  - y_next+PLAYER_H >= FLOOR_Y: pos_y=FLOOR_Y-PLAYER_H, vy=0, state GROUND. This includes landing from AIR1/AIR2.
  - y_next < 0: pos_y=0, vy=0, state unchanged.
  - GROUND with vy_new=0 stays at its current y.
- Horizontal motion:
  - Exactly one of left/right held: x ± WALK_SPEED, clamped to [0, SCREEN_W-PLAYER_W]; facing follows the held direction.
  - Both or neither held: x and facing unchanged.
- Inputs need no synchronisation; they are sampled only at the step strobe.

Decomposition:
- Shared game_pkg:
  - state encodings: GROUND=0, AIR1=1, AIR2=2, DEAD=3
  - SCREEN_W/H defaults and sprite sizes, shared with render
- One sub-module: edge_sync, holding the 2-FF synchroniser and rising-edge pulse, with ports clk/rst/din/rise. It is reusable for future button or tick inputs.

Test Plan:
1. Fall and land: rst, then 20 update_clk rises with no buttons → vy runs 1..9 then stays 9; landing on step 18 gives pos_y=420, state=GROUND, vy=0.
2. Ground jump: from pos_y=420 GROUND, btn_jump high for one step → pos_y=412, state=AIR1.
   - Next step with no press: pos_y=405 (vy=-7).
   - Release, then press again: vy=-7 applied, state=AIR2.
   - Third press: no effect.
3. Held jump: btn_jump held for 40 steps from GROUND → exactly one jump and no double jump; lands again in GROUND.
4. Walls: btn_left held from x=40 → x=37, 34, ..., clamped to 0 on step 14 with facing=0. Both buttons held → x and facing unchanged. Right held from x=619 → 620.
5. Death: hazard=1 for one step → state=DEAD, deaths=1. Position frozen for 10 steps even with hazard toggling. Jump press → (40,300) in AIR1. 256 deaths → deaths stays 255.
6. Strobe/reset: update_clk held high 1000 clk → single step. rst asserted on the same clk as the strobe → all reset values, no step applied.
